// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic multiplier: FSM states, LFSR tap
// masks and the bit-reversal used to decorrelate the second bitstream.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Fibonacci feedback mask for a maximal-length LFSR of width w.
    // Bit i set means register bit i feeds the XOR. A zero mask marks an
    // unsupported width; the LFSR rejects it at elaboration.
    function automatic logic [15:0] lfsr_taps(input int w);
        logic [15:0] mask;
        case (w)
            8:       mask = 16'h00B8;  // x^8  + x^6  + x^5  + x^4 + 1
            10:      mask = 16'h0240;  // x^10 + x^7  + 1
            12:      mask = 16'h0829;  // x^12 + x^6  + x^4  + x   + 1
            16:      mask = 16'hD008;  // x^16 + x^15 + x^13 + x^4 + 1
            default: mask = 16'h0000;
        endcase
        return mask;
    endfunction

    // Reverse the low w bits of x; bits at and above w are discarded.
    function automatic logic [15:0] bitrev(input logic [15:0] x, input int unsigned w);
        logic [15:0] r;
        r = {<<{x}};
        return r >> (16 - w);
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR used as the shared random source of the
// stochastic number generator. Loads SEED on request, steps when enabled,
// otherwise holds. The all-zero lock-up state is never reachable.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int W    = 8,
    parameter int SEED = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [15:0]  TAPS_FULL = lfsr_taps(W);
    localparam logic [W-1:0] TAPS      = TAPS_FULL[W-1:0];
    localparam logic [W-1:0] SEED_V    = W'(SEED);

    // Reject unsupported widths and a seed that would lock the LFSR at zero.
    if (TAPS_FULL == 16'h0000) begin : g_bad_width
        $error("sc_lfsr: unsupported width W=%0d (use 8, 10, 12 or 16)", W);
    end
    if (SEED == 0 || SEED >= (1 << W)) begin : g_bad_seed
        $error("sc_lfsr: SEED=%0d must be nonzero and below 2^W", SEED);
    end

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next state: reload has priority over stepping; otherwise hold.
    always_comb begin
        // NOTE: assign a default before any branch so every path drives q_d
        // and no latch is inferred.
        q_d = q_q;
        if (load) begin
            q_d = SEED_V;
        end else if (en) begin
            q_d = {q_q[W-2:0], ^(q_q & TAPS)};
        end
    end

    // State register; the reset value equals the job-start seed.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            q_q <= SEED_V;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sc_mult_seq.sv
// Serial unipolar stochastic multiplier. One operand pair is accepted over a
// valid/ready handshake, two bitstreams are derived from one LFSR (plain and
// bit-reversed), their AND is counted for STREAM_LEN cycles and the count is
// returned over a second valid/ready handshake.
module sc_mult_seq
    import sc_pkg::*;
#(
    parameter  int W          = 8,
    parameter  int STREAM_LEN = 255,
    parameter  int SEED       = 1,
    localparam int CW         = $clog2(STREAM_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    output logic          y_bit,
    output logic          y_bit_valid,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] y_count,
    output logic          busy
);

    // The stream must fit in one LFSR period so no random value repeats.
    if (STREAM_LEN < 1 || STREAM_LEN > (1 << W) - 1) begin : g_bad_len
        $error("sc_mult_seq: STREAM_LEN=%0d outside 1..2^W-1", STREAM_LEN);
    end

    localparam logic [CW-1:0] LAST_BEAT = CW'(STREAM_LEN - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] y_count_q, y_count_d;

    logic          in_idle;
    logic          in_run;
    logic          accept;
    logic          lfsr_load;
    logic          lfsr_en;
    logic [W-1:0]  lfsr_q;
    logic [W-1:0]  lfsr_rev;
    logic          a_bit;
    logic          b_bit;

    assign in_idle = (state_q == IDLE);
    assign in_run  = (state_q == RUN);

    // A job is taken only in IDLE and never in a cycle that also aborts.
    assign accept    = in_idle & in_valid & ~clear;
    assign lfsr_load = accept;
    assign lfsr_en   = in_run & ~clear;

    sc_lfsr #(
        .W    (W),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    // Stochastic number generator: comparing the same random value in two
    // bit orders gives two streams with low mutual correlation.
    assign lfsr_rev = W'(bitrev(16'(lfsr_q), W));
    assign a_bit    = (lfsr_q < a_q);
    assign b_bit    = (lfsr_rev < b_q);
    assign y_bit    = in_run & a_bit & b_bit;

    // FSM and datapath next-state; clear overrides every transition.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        y_count_d = y_count_q;

        if (clear) begin
            state_d = IDLE;
            beat_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d     = a_in;
                        b_d     = b_in;
                        beat_d  = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    cnt_d  = cnt_q + CW'(y_bit);
                    beat_d = beat_q + CW'(1);
                    if (beat_q == LAST_BEAT) begin
                        // Include this cycle's bit, which cnt_q does not yet hold.
                        y_count_d = cnt_q + CW'(y_bit);
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    // y_count keeps its value after the handshake.
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Registers for FSM state, latched operands, beat, count and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            y_count_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            y_count_q <= y_count_d;
        end
    end

    // Handshake and status outputs are pure decodes of the state register.
    assign in_ready    = in_idle;
    assign y_bit_valid = in_run;
    assign out_valid   = (state_q == DONE);
    assign busy        = ~in_idle;
    assign y_count     = y_count_q;

endmodule
